// File: rtl/fetch_issue_pkg.sv
// Shared widths, bubble encoding, fetch FSM states and opcode values for the
// fetch/issue front end.
package fetch_issue_pkg;
    localparam int ISIZE = 16;
    localparam int ASIZE = 16;

    // ADD R0,R0,R0 writes R0, so it never matches a forwarding source.
    localparam logic [ISIZE-1:0] NOP = '0;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } fetchState_e;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_LW   = 4'h8,
        OP_SW   = 4'h9,
        OP_B    = 4'hC,
        OP_JAL  = 4'hD,
        OP_JR   = 4'hE,
        OP_EXEC = 4'hF
    } opcode_e;
endpackage

// File: rtl/fetch_issue_if.sv
// Instruction-memory request/response bus: one outstanding request, and the
// response (ack + data) arrives combinationally in the cycle it is accepted.
interface fetch_issue_if #(
    parameter int ISIZE = 16,
    parameter int ASIZE = 16
);
    logic             imem_req;
    logic [ASIZE-1:0] imem_addr;
    logic             imem_ack;
    logic [ISIZE-1:0] imem_data;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_data);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_data);
endinterface

// File: rtl/fetch_skid.sv
// One-entry holding register for a word that arrived while decode was stalled.
module fetch_skid #(
    parameter int ISIZE = 16,
    parameter int ASIZE = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clear,
    input  logic [ISIZE-1:0] dataIn,
    input  logic [ASIZE-1:0] addrIn,
    output logic             valid,
    output logic [ISIZE-1:0] data,
    output logic [ASIZE-1:0] addr
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            addr  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= dataIn;
            addr  <= addrIn;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/fetch_issue.sv
// Fetch stage feeding decode: word-addressed instruction fetch with a skid
// entry for stalls and a flush state for redirects that race a pending request.
import fetch_issue_pkg::*;

module fetch_issue #(
    parameter int               ISIZE    = fetch_issue_pkg::ISIZE,
    parameter int               ASIZE    = fetch_issue_pkg::ASIZE,
    parameter logic [ASIZE-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_issue_if.master      imem,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ASIZE-1:0]   redirect_pc,
    output logic [ISIZE-1:0]   Instr,
    output logic               InstrValid,
    output logic [ASIZE-1:0]   PC,
    output logic [ASIZE-1:0]   NextPC,
    output logic [ISIZE-1:0]   LastInstr,
    output logic [ISIZE-1:0]   Last2Instr
);
    localparam logic [ISIZE-1:0] BUBBLE = ISIZE'(NOP);

    fetchState_e state, nState;
    logic             reqReg, nReq;
    logic [ASIZE-1:0] fetchPtr, nPtr, flushTarget, nTarget;
    logic [ISIZE-1:0] instrReg, nInstr, lastReg, nLast, last2Reg, nLast2;
    logic [ASIZE-1:0] pcReg, nPc;
    logic             validReg, nValid;
    logic             ack, skidLoad, skidClear, skidValid;
    logic [ISIZE-1:0] skidData;
    logic [ASIZE-1:0] skidAddr;

    fetch_skid #(.ISIZE(ISIZE), .ASIZE(ASIZE)) uSkid (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (skidLoad),
        .clear  (skidClear),
        .dataIn (imem.imem_data),
        .addrIn (fetchPtr),
        .valid  (skidValid),
        .data   (skidData),
        .addr   (skidAddr)
    );

    // Gating with reqReg drops any ack seen before the first post-reset request.
    assign ack = imem.imem_ack & reqReg;

    always_comb begin
        nState    = state;
        nPtr      = fetchPtr;
        nTarget   = flushTarget;
        nInstr    = instrReg;
        nValid    = validReg;
        nPc       = pcReg;
        nLast     = stall ? BUBBLE : instrReg;
        nLast2    = lastReg;
        skidLoad  = 1'b0;
        skidClear = 1'b0;
        case (state)
            FETCH: begin
                if (stall) begin
                    if (ack) begin
                        skidLoad = 1'b1;
                        nState   = HOLD;
                    end
                end else if (redirect) begin
                    nInstr = BUBBLE;
                    nValid = 1'b0;
                    if (ack || !reqReg) begin
                        nPtr = redirect_pc;
                    end else begin
                        nTarget = redirect_pc;
                        nState  = FLUSH;
                    end
                end else if (ack) begin
                    nInstr = imem.imem_data;
                    nValid = 1'b1;
                    nPc    = fetchPtr;
                    nPtr   = fetchPtr + ASIZE'(1);
                end else begin
                    nInstr = BUBBLE;
                    nValid = 1'b0;
                end
            end
            HOLD: begin
                if (!stall) begin
                    skidClear = 1'b1;
                    nState    = FETCH;
                    if (redirect) begin
                        nInstr = BUBBLE;
                        nValid = 1'b0;
                        nPtr   = redirect_pc;
                    end else begin
                        nInstr = skidData;
                        nValid = skidValid;
                        nPc    = skidAddr;
                        nPtr   = skidAddr + ASIZE'(1);
                    end
                end
            end
            FLUSH: begin
                if (!stall) begin
                    nInstr = BUBBLE;
                    nValid = 1'b0;
                    if (redirect) nTarget = redirect_pc;
                end
                // The stale response is dropped even under stall; it carries nothing useful.
                if (ack) begin
                    nPtr   = (!stall && redirect) ? redirect_pc : flushTarget;
                    nState = FETCH;
                end
            end
            default: nState = FETCH;
        endcase
        nReq = (nState != HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            reqReg      <= 1'b0;
            fetchPtr    <= RESET_PC;
            flushTarget <= RESET_PC;
            instrReg    <= BUBBLE;
            validReg    <= 1'b0;
            pcReg       <= RESET_PC;
            lastReg     <= BUBBLE;
            last2Reg    <= BUBBLE;
        end else begin
            state       <= nState;
            reqReg      <= nReq;
            fetchPtr    <= nPtr;
            flushTarget <= nTarget;
            instrReg    <= nInstr;
            validReg    <= nValid;
            pcReg       <= nPc;
            lastReg     <= nLast;
            last2Reg    <= nLast2;
        end
    end

    assign imem.imem_req  = reqReg;
    assign imem.imem_addr = fetchPtr;
    assign Instr          = instrReg;
    assign InstrValid     = validReg;
    assign PC             = pcReg;
    assign NextPC         = pcReg + ASIZE'(1);
    assign LastInstr      = lastReg;
    assign Last2Instr     = last2Reg;
endmodule

// File: tb/tb_fetch_issue.sv
// Directed bench for fetch_issue: streaming fetch, stall skid, redirect races,
// address wrap and asynchronous reset during a flush.
module tb_fetch_issue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, redirect, ackOn;
    logic [15:0] redirectPc;
    logic [15:0] Instr, PC, NextPC, LastInstr, Last2Instr;
    logic        InstrValid;
    int          total = 0;
    int          bad = 0;

    fetch_issue_if #(.ISIZE(16), .ASIZE(16)) imem();

    // Memory model: always returns addr|0x1000 in the same cycle as ack.
    assign imem.imem_ack  = ackOn;
    assign imem.imem_data = imem.imem_addr | 16'h1000;

    fetch_issue #(.ISIZE(16), .ASIZE(16), .RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (imem),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirectPc),
        .Instr       (Instr),
        .InstrValid  (InstrValid),
        .PC          (PC),
        .NextPC      (NextPC),
        .LastInstr   (LastInstr),
        .Last2Instr  (Last2Instr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirectPc = '0; ackOn = 1'b1;
        #3;
        chk("rst_req",   {15'd0, imem.imem_req}, 16'h0000);
        chk("rst_addr",  imem.imem_addr, 16'h0000);
        chk("rst_instr", Instr, 16'h0000);
        chk("rst_valid", {15'd0, InstrValid}, 16'h0000);
        chk("rst_pc",    PC, 16'h0000);
        chk("rst_last",  LastInstr, 16'h0000);
        chk("rst_last2", Last2Instr, 16'h0000);
        #9 rst_n = 1'b1;

        // Ack on the release cycle is ignored; request rises at RESET_PC.
        tick();
        chk("start_req",   {15'd0, imem.imem_req}, 16'h0001);
        chk("start_addr",  imem.imem_addr, 16'h0000);
        chk("start_valid", {15'd0, InstrValid}, 16'h0000);
        tick();
        chk("s0_instr", Instr, 16'h1000);
        chk("s0_valid", {15'd0, InstrValid}, 16'h0001);
        chk("s0_pc",    PC, 16'h0000);
        chk("s0_npc",   NextPC, 16'h0001);
        chk("s0_last",  LastInstr, 16'h0000);
        tick();
        chk("s1_instr", Instr, 16'h1001);
        chk("s1_last",  LastInstr, 16'h1000);
        tick();
        chk("s2_instr", Instr, 16'h1002);
        chk("s2_last",  LastInstr, 16'h1001);
        chk("s2_last2", Last2Instr, 16'h1000);
        tick();
        tick();
        chk("pre_stall_addr", imem.imem_addr, 16'h0005);

        // Stall coincides with the ack for word 5.
        stall = 1'b1;
        tick();
        chk("hold_req",   {15'd0, imem.imem_req}, 16'h0000);
        chk("hold_instr", Instr, 16'h1004);
        chk("hold_pc",    PC, 16'h0004);
        chk("hold_last",  LastInstr, 16'h0000);
        chk("hold_last2", Last2Instr, 16'h1003);
        stall = 1'b0;
        tick();
        chk("rel_instr", Instr, 16'h1005);
        chk("rel_pc",    PC, 16'h0005);
        chk("rel_addr",  imem.imem_addr, 16'h0006);
        chk("rel_req",   {15'd0, imem.imem_req}, 16'h0001);

        // Redirect while the request to 6 is still pending.
        ackOn = 1'b0; redirect = 1'b1; redirectPc = 16'h0040;
        tick();
        redirect = 1'b0;
        chk("fl_addr",  imem.imem_addr, 16'h0006);
        chk("fl_instr", Instr, 16'h0000);
        chk("fl_valid", {15'd0, InstrValid}, 16'h0000);
        chk("fl_req",   {15'd0, imem.imem_req}, 16'h0001);
        chk("fl_last",  LastInstr, 16'h1005);
        tick();
        tick();
        chk("fl_addr_stable", imem.imem_addr, 16'h0006);
        chk("fl_instr_nop",   Instr, 16'h0000);
        ackOn = 1'b1;
        tick();
        chk("fl_done_addr",  imem.imem_addr, 16'h0040);
        chk("fl_done_instr", Instr, 16'h0000);
        tick();
        chk("tgt_instr", Instr, 16'h1040);
        chk("tgt_pc",    PC, 16'h0040);

        // Redirect and ack in the same cycle: word 0x41 is dropped.
        redirect = 1'b1; redirectPc = 16'h0020;
        tick();
        redirect = 1'b0;
        chk("ra_addr",  imem.imem_addr, 16'h0020);
        chk("ra_instr", Instr, 16'h0000);
        chk("ra_valid", {15'd0, InstrValid}, 16'h0000);
        chk("ra_last",  LastInstr, 16'h1040);
        tick();
        chk("ra_next_instr", Instr, 16'h1020);

        // Wrap at the top of the address space.
        redirect = 1'b1; redirectPc = 16'hFFFF;
        tick();
        redirect = 1'b0;
        chk("wrap_addr_ffff", imem.imem_addr, 16'hFFFF);
        tick();
        chk("wrap_addr", imem.imem_addr, 16'h0000);
        chk("wrap_pc",   PC, 16'hFFFF);
        chk("wrap_npc",  NextPC, 16'h0000);
        chk("wrap_instr", Instr, 16'hFFFF);
        tick();
        chk("wrap_next_instr", Instr, 16'h1000);
        chk("wrap_next_addr",  imem.imem_addr, 16'h0001);

        // Enter FLUSH, then reset asynchronously between edges.
        ackOn = 1'b0; redirect = 1'b1; redirectPc = 16'h0030;
        tick();
        redirect = 1'b0;
        chk("pr_addr",  imem.imem_addr, 16'h0001);
        chk("pr_last",  LastInstr, 16'h1000);
        chk("pr_last2", Last2Instr, 16'hFFFF);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_req",   {15'd0, imem.imem_req}, 16'h0000);
        chk("ar_addr",  imem.imem_addr, 16'h0000);
        chk("ar_instr", Instr, 16'h0000);
        chk("ar_valid", {15'd0, InstrValid}, 16'h0000);
        chk("ar_pc",    PC, 16'h0000);
        chk("ar_last",  LastInstr, 16'h0000);
        chk("ar_last2", Last2Instr, 16'h0000);
        ackOn = 1'b1;
        #1 rst_n = 1'b1;
        tick();
        chk("rs_req",   {15'd0, imem.imem_req}, 16'h0001);
        chk("rs_addr",  imem.imem_addr, 16'h0000);
        chk("rs_instr", Instr, 16'h0000);
        tick();
        chk("rs_first_instr", Instr, 16'h1000);
        chk("rs_first_valid", {15'd0, InstrValid}, 16'h0001);
        chk("rs_first_addr",  imem.imem_addr, 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
